// File: rtl/conv_window_streamer.sv
// Raster-order 1-bit pixel stream in, WINxWIN sliding windows (stride STRIDE) out.
// A WIN-row circular line buffer feeds a window register that is loaded on each trigger pixel.
module conv_window_streamer #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int WIN    = 6,
  parameter int STRIDE = 2,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pixel,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          win_image [0:WIN-1][0:WIN-1],
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          win_last
);

  localparam int SW  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int NWX = (IMG_W - WIN) / STRIDE + 1;
  localparam int NWY = (IMG_H - WIN) / STRIDE + 1;

  localparam logic [RW-1:0] ROW_FIRST     = RW'(WIN - 1);
  localparam logic [CW-1:0] COL_FIRST     = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_END       = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_END       = CW'(IMG_W - 1);
  localparam logic [SW-1:0] SLOT_END      = SW'(WIN - 1);
  localparam logic [RW-1:0] LAST_TOP_ROW  = RW'((NWY - 1) * STRIDE);
  localparam logic [CW-1:0] LAST_TOP_COL  = CW'((NWX - 1) * STRIDE);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both 1.
  // valid never waits on ready; once raised, win_valid and its payload stay put until taken.
  logic          accept;
  logic          trig;
  logic [RW-1:0] top_row;
  logic [CW-1:0] top_col;

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          lb_q [0:WIN-1][0:IMG_W-1];

  logic          valid_q, valid_d;
  logic          img_q [0:WIN-1][0:WIN-1];
  logic          img_d [0:WIN-1][0:WIN-1];
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_q, last_d;

  assign in_ready  = !valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  assign win_valid = valid_q;
  assign win_image = img_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign win_last  = last_q;

  // Trigger: the pixel completing the bottom-right corner of a stride-aligned window.
  always_comb begin
    top_row = r_q - ROW_FIRST;
    top_col = c_q - COL_FIRST;
    trig    = accept
              && (r_q >= ROW_FIRST) && (c_q >= COL_FIRST)
              && ((32'(top_row) % STRIDE) == 0)
              && ((32'(top_col) % STRIDE) == 0);
  end

  // slot tracks r mod WIN; it restarts at 0 with every frame.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    slot_d = slot_q;
    if (accept) begin
      if (c_q == COL_END) begin
        c_d = '0;
        if (r_q == ROW_END) begin
          r_d    = '0;
          slot_d = '0;
        end else begin
          r_d    = r_q + 1'b1;
          slot_d = (slot_q == SLOT_END) ? '0 : slot_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Window row i lives in slot (slot+1+i) mod WIN, which puts the oldest buffered row on top.
  always_comb begin
    img_d   = img_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && win_ready) begin
      valid_d = 1'b0;
    end
    if (trig) begin
      valid_d = 1'b1;
      row_d   = top_row;
      col_d   = top_col;
      last_d  = (top_row == LAST_TOP_ROW) && (top_col == LAST_TOP_COL);
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          img_d[i][j] = lb_q[SW'((32'(slot_q) + 32'(i) + 32'd1) % WIN)]
                            [CW'(32'(top_col) + 32'(j))];
        end
      end
      img_d[WIN-1][WIN-1] = in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      c_q     <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          img_q[i][j] <= 1'b0;
        end
        for (int k = 0; k < IMG_W; k++) begin
          lb_q[i][k] <= 1'b0;
        end
      end
    end else begin
      r_q     <= r_d;
      c_q     <= c_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      img_q   <= img_d;
      if (accept) begin
        lb_q[slot_q][c_q] <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Bench for conv_window_streamer: whole-frame window model, expected queue, per-cycle compare.
module tb_conv_window_streamer;

  localparam int IMG_W  = 12;
  localparam int IMG_H  = 12;
  localparam int WIN    = 6;
  localparam int STRIDE = 2;
  localparam int NWX    = (IMG_W - WIN) / STRIDE + 1;
  localparam int NWY    = (IMG_H - WIN) / STRIDE + 1;
  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int IB     = WIN * WIN;
  localparam int W      = IB + CW + RW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_pixel;
  logic          win_valid;
  logic          win_ready;
  logic          win_image [0:WIN-1][0:WIN-1];
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_last;

  always #5 clk = ~clk;

  conv_window_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .win_valid(win_valid), .win_ready(win_ready), .win_image(win_image),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic frame_px [0:IMG_H-1][0:IMG_W-1];

  int acc_cnt = 0;
  int win_cnt = 0;
  int ones_cnt = 0;
  bit check_first = 0;
  bit prev_acc = 0;
  bit have_hold = 0;
  logic [W-1:0] hold_word;

  int rdy_mode = 0;
  int stall_left = 0;
  bit stall_done = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Word layout: {last, row, col, image bits with bit i*WIN+j = image[i][j]}.
  function automatic logic [W-1:0] model_window(input int wy, input int wx);
    logic [W-1:0] v;
    int r0, c0;
    r0 = wy * STRIDE;
    c0 = wx * STRIDE;
    v = '0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        v[i*WIN+j] = frame_px[r0+i][c0+j];
    v[IB +: CW]      = CW'(c0);
    v[IB+CW +: RW]   = RW'(r0);
    v[W-1]           = (wy == NWY-1) && (wx == NWX-1);
    return v;
  endfunction

  function automatic logic [W-1:0] dut_window();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        v[i*WIN+j] = win_image[i][j];
    v[IB +: CW]    = win_col;
    v[IB+CW +: RW] = win_row;
    v[W-1]         = win_last;
    return v;
  endfunction

  task automatic expect_frame();
    for (int wy = 0; wy < NWY; wy++)
      for (int wx = 0; wx < NWX; wx++)
        exp_q.push_back(model_window(wy, wx));
  endtask

  task automatic set_frame_const(input logic v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame_px[r][c] = v;
  endtask

  task automatic set_frame_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame_px[r][c] = 1'($urandom_range(0, 1));
  endtask

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      win_ready = 1'($urandom_range(0, 1));
      stall_done = 0;
    end else if (rdy_mode == 2) begin
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end else if (win_valid && !stall_done) begin
        win_ready = 1'b0;
        stall_left = 9;
      end else begin
        win_ready = 1'b1;
      end
    end else begin
      win_ready = 1'b1;
      stall_done = 0;
    end
  end

  // ---------------- compare process (negedge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      have_hold = 0;
      prev_acc  = 0;
    end else begin
      check("in_ready_rule", W'(in_ready), W'(!win_valid || win_ready));
      if (have_hold) begin
        check("stall_valid_held", W'(win_valid), W'(1));
        check("stall_window_held", dut_window(), hold_word);
      end
      if (win_valid && !win_ready) begin
        have_hold = 1;
        hold_word = dut_window();
      end else begin
        have_hold = 0;
      end
      if (win_valid && check_first) begin
        check("first_window_pixel_count", W'(acc_cnt), W'(66));
        check("first_window_prev_cycle_accept", W'(prev_acc), W'(1));
        check_first = 0;
      end
      if (win_valid && win_ready) begin
        win_cnt++;
        if (|dut_window()[IB-1:0]) ones_cnt++;
        if (exp_q.size() == 0) check("unexpected_window", W'(1), W'(0));
        else check("window", dut_window(), exp_q.pop_front());
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) acc_cnt++;
    end
  end

  // ---------------- producer driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic send_pixel(input logic px, input int gap_pct);
    int waited;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pixel = px;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("pixel_accept_timeout", W'(0), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap_pct);
    for (int k = 0; k < n; k++)
      send_pixel(frame_px[k / IMG_W][k % IMG_W], gap_pct);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    check("drain_queue_empty", W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_win_valid"}, W'(win_valid), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_window_word"}, dut_window(), W'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_w, base_o, base_a;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Steady flow, all ones
    set_frame_const(1'b1);
    check("model_ones_last_window", model_window(NWY-1, NWX-1), {1'b1, 4'd6, 4'd6, 36'hF_FFFF_FFFF});
    check("model_ones_first_window", model_window(0, 0), {1'b0, 4'd0, 4'd0, 36'hF_FFFF_FFFF});
    expect_frame();
    base_w = win_cnt;
    check_first = 1;
    send_pixels(IMG_W * IMG_H, 0);
    drain();
    check("s1_window_count", W'(win_cnt - base_w), W'(16));
    check("s1_first_window_seen", W'(check_first), W'(0));

    // Single set pixel at (7,9)
    set_frame_const(1'b0);
    frame_px[7][9] = 1'b1;
    check("model_single_win_2_4", model_window(1, 2), {1'b0, 4'd2, 4'd4, 36'h8_0000_0000});
    check("model_single_win_6_6", model_window(3, 3), {1'b1, 4'd6, 4'd6, 36'h0_0000_0200});
    expect_frame();
    base_w = win_cnt;
    base_o = ones_cnt;
    send_pixels(IMG_W * IMG_H, 0);
    drain();
    check("s2_window_count", W'(win_cnt - base_w), W'(16));
    check("s2_windows_with_one", W'(ones_cnt - base_o), W'(6));

    // Output backpressure: 10-cycle stall on the first window
    set_frame_const(1'b1);
    rdy_mode = 2;
    expect_frame();
    base_w = win_cnt;
    send_pixels(IMG_W * IMG_H, 0);
    drain();
    check("s3_stall_happened", W'(stall_done), W'(1));
    check("s3_window_count", W'(win_cnt - base_w), W'(16));
    rdy_mode = 0;

    // Input gaps plus random consumer on the single-pixel frame
    set_frame_const(1'b0);
    frame_px[7][9] = 1'b1;
    rdy_mode = 1;
    expect_frame();
    base_w = win_cnt;
    base_o = ones_cnt;
    send_pixels(IMG_W * IMG_H, 30);
    drain();
    check("s4_window_count", W'(win_cnt - base_w), W'(16));
    check("s4_windows_with_one", W'(ones_cnt - base_o), W'(6));
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset mid-frame after 40 pixels
    set_frame_const(1'b1);
    send_pixels(40, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_state("midreset");
    base_a = acc_cnt;
    expect_frame();
    base_w = win_cnt;
    check_first = 1;
    acc_cnt = acc_cnt - base_a;
    send_pixels(IMG_W * IMG_H, 0);
    drain();
    check("s5_window_count", W'(win_cnt - base_w), W'(16));

    // Back-to-back frames: ones then zeros
    base_w = win_cnt;
    base_o = ones_cnt;
    set_frame_const(1'b1);
    expect_frame();
    send_pixels(IMG_W * IMG_H, 0);
    set_frame_const(1'b0);
    expect_frame();
    send_pixels(IMG_W * IMG_H, 0);
    drain();
    check("s6_window_count", W'(win_cnt - base_w), W'(32));
    check("s6_windows_with_one", W'(ones_cnt - base_o), W'(16));

    // Random frames with random gaps and consumer
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      set_frame_random();
      expect_frame();
      base_w = win_cnt;
      send_pixels(IMG_W * IMG_H, 25);
      drain();
      check("s7_window_count", W'(win_cnt - base_w), W'(16));
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
